// File: rtl/flex_updown_counter.sv
// flex_updown_counter: up/down counter with programmable rollover value,
// synchronous clear and parallel load. The counting range is 1..rollover_val.
// rollover_flag and underflow_flag are registered and change on the same
// edge as count_out.
// Optional build macro FLEX_CNT_SAT_EN adds a 'saturate' input. When
// saturate=1 the counter holds at the ends of its range instead of wrapping.
module flex_updown_counter #(
  parameter int SIZE = 4
) (
  input  logic            clk,
  input  logic            n_rst,
  input  logic            clear,
  input  logic            load,
  input  logic [SIZE-1:0] load_val,
  input  logic            count_enable,
  input  logic            up_down,
  input  logic [SIZE-1:0] rollover_val,
`ifdef FLEX_CNT_SAT_EN
  input  logic            saturate,
`endif
  output logic [SIZE-1:0] count_out,
  output logic            rollover_flag,
  output logic            underflow_flag
);

  localparam logic [SIZE-1:0] ZERO = '0;
  localparam logic [SIZE-1:0] ONE  = SIZE'(1);

  logic [SIZE-1:0] count_q, count_d;
  logic            rollover_q, rollover_d;
  logic            underflow_q, underflow_d;
  logic            sat_mode;

`ifdef FLEX_CNT_SAT_EN
  assign sat_mode = saturate;
`else
  assign sat_mode = 1'b0;
`endif

  // One up step. A count at or above the terminal value either wraps to 1
  // or, in saturate mode, pins to the terminal value. A count above a newly
  // lowered terminal value takes this same path.
  function automatic logic [SIZE-1:0] step_up(input logic [SIZE-1:0] cur,
                                              input logic [SIZE-1:0] rv,
                                              input logic            sat);
    if (cur >= rv) step_up = sat ? rv : ONE;
    else           step_up = cur + ONE;
  endfunction

  // One down step. A count at 1 or 0 either wraps to the terminal value or,
  // in saturate mode, pins to 1.
  function automatic logic [SIZE-1:0] step_down(input logic [SIZE-1:0] cur,
                                                input logic [SIZE-1:0] rv,
                                                input logic            sat);
    if (cur <= ONE) step_down = sat ? ONE : rv;
    else            step_down = cur - ONE;
  endfunction

  // Next-count selection (clear > load > count > hold) and next-flag decode.
  // A zero rollover_val disables counting but still lets clear and load act.
  always_comb begin
    count_d = count_q;
    if (clear) begin
      count_d = ZERO;
    end else if (load) begin
      count_d = load_val;
    end else if (count_enable && (rollover_val != ZERO)) begin
      if (up_down) count_d = step_up(count_q, rollover_val, sat_mode);
      else         count_d = step_down(count_q, rollover_val, sat_mode);
    end
    // The flags are decoded from the next count, so they line up with count_out.
    rollover_d  = (rollover_val != ZERO) && (count_d == rollover_val);
    underflow_d = (rollover_val != ZERO) && (count_d == ONE);
  end

  // Count and flag registers with asynchronous active-low reset.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      count_q     <= ZERO;
      rollover_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      count_q     <= count_d;
      rollover_q  <= rollover_d;
      underflow_q <= underflow_d;
    end
  end

  assign count_out      = count_q;
  assign rollover_flag  = rollover_q;
  assign underflow_flag = underflow_q;

endmodule

// File: doc/flex_updown_counter.md
Name: flex_updown_counter

Overview:
Parametrised successor to the lab flex counter: an up/down counter with programmable rollover value, synchronous clear and parallel load. It supports separate up-terminal and down-terminal flags. It sits in timer and bit/byte-count datapaths (e.g. serial receivers, timer blocks) where software-set periods and bidirectional counting are required.

Parameters:
SIZE, 4, width of count, load and rollover values in bits (legal range 2..32)

Ports:
clk  input  1  system clock, rising-edge
n_rst  input  1  asynchronous active-low reset
clear  input  1  synchronous clear to 0, highest priority
load  input  1  synchronous parallel load of load_val
load_val  input  SIZE  value loaded when load=1
count_enable  input  1  advance count one step this cycle
up_down  input  1  1 = count up, 0 = count down
rollover_val  input  SIZE  terminal value of count range 1..rollover_val
count_out  output  SIZE  registered current count
rollover_flag  output  1  registered; high while count_out == rollover_val
underflow_flag  output  1  registered; high while count_out == 1 and rollover_val != 0

Behaviour:
- Reset: the clock is clk; reset is n_rst, asynchronous and active-low. While n_rst=0: count_out=0, rollover_flag=0, underflow_flag=0, regardless of clk. Reset asserted mid-count takes effect immediately. The first count after release starts from 0.
- Per-edge priority: clear > load > count_enable > hold.
- clear=1: next count = 0.
- load=1 (clear=0): next count = load_val. It is loaded raw and not clamped, even if load_val > rollover_val.
- Count up (count_enable=1, up_down=1): if count_out >= rollover_val, next = 1; else next = count_out + 1.
  - Example: rollover_val=7 gives the sequence 0,1..7,1,2...
- Count down (count_enable=1, up_down=0): if count_out <= 1, next = rollover_val; else next = count_out - 1.
  - Example: starting from 0 with rollover_val=7 gives 7,6..1,7...
- rollover_val = 0: counting is inhibited; count holds. clear and load still act. Both flags are 0.
- count_enable=0: count holds. Direction changes take effect on the next enabled edge, with no extra cycle.
- Flags are registered from the next-state count and the current rollover_val, so they are coincident with count_out (zero-latency relative to count_out).
  - rollover_flag = (next_count == rollover_val) and rollover_val != 0.
  - underflow_flag = (next_count == 1) and rollover_val != 0.
- rollover_val = 1: count sits at 1 after the first enabled step, and both flags are high.
- rollover_val changed mid-count: wrap comparisons use the new value from the next edge on. A count above the new value wraps per the >= / <= rules above.
- Arithmetic is SIZE-bit unsigned; no carry out. The wrap rules make overflow/underflow of the raw adder unreachable.

Optional Feature:
FLEX_CNT_SAT_EN
- Defined: adds input port saturate (1 bit).
  - With saturate=1, up-counting holds at rollover_val instead of wrapping to 1.
  - With saturate=1, down-counting holds at 1 instead of wrapping to rollover_val. From count 0, down-counting goes to 1.
  - Flags stay asserted while saturated.
  - saturate=0 behaves as wrap mode.
- Undefined: the saturate port does not exist; the counter always wraps as above.

Test Plan:
1. Reset and hold: n_rst=0 mid-count at count 5 -> count_out=0 and flags=0 immediately, without waiting for clk. Release, enable=0 for 2 cycles -> count stays 0.
2. Up wrap, rollover_val=7, up_down=1, enable for 7 edges -> count_out=7, rollover_flag=1 in the same cycle. Next edge -> count_out=1, rollover_flag=0, underflow_flag=1.
3. Down wrap, rollover_val=5, from count 0, up_down=0, enable -> sequence 5,4,3,2,1,5. underflow_flag=1 only while count=1; rollover_flag=1 while count=5.
4. Priority: clear=1, load=1, load_val=9, enable=1 -> count_out=0. Then clear=0, load=1 -> count_out=9 with rollover_val=7. One up step -> 1.
5. Boundaries: rollover_val=0 with enable=1 for 3 edges -> count holds and both flags are 0. rollover_val=1 -> count goes to 1 and stays; both flags are 1. Change rollover_val 15 -> 3 while count=10 and counting up -> next = 1.
6. FLEX_CNT_SAT_EN builds only: saturate=1, rollover_val=4, up for 6 edges -> count_out=4 held, rollover_flag=1. Then down for 6 edges -> count_out=1 held, underflow_flag=1.
